// File: rtl/uart_pkg.sv
// Shared types and parameter limits for the configurable UART transmitter.
// Build option: UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

   localparam int unsigned CLKS_MIN      = 2;
   localparam int unsigned CLKS_MAX      = 65535;
   localparam int unsigned DATA_BITS_MIN = 5;
   localparam int unsigned DATA_BITS_MAX = 9;
   localparam int unsigned STOP_BITS_MIN = 1;
   localparam int unsigned STOP_BITS_MAX = 2;

   // Wide enough to index DATA_BITS_MAX payload bits and the stop bits
   localparam int unsigned BIT_CNT_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter; reloads at every bit boundary and strobes bit_tick
// in the last cycle of each bit. Held at zero while the frame is inactive.
module uart_baud_cnt #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic bit_tick,
   output logic near_tick_c
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         bit_tick <= 1'b0;
      end else if (!en) begin
         cnt      <= '0;
         bit_tick <= 1'b0;
      end else if (cnt == '0) begin
         cnt      <= CNT_W'(CLKS_PER_BIT - 1);
         bit_tick <= 1'b0;
      end else begin
         cnt      <= cnt - CNT_W'(1);
         bit_tick <= (cnt == CNT_W'(1));
      end
   end

   // One cycle before the bit boundary
   assign near_tick_c = (cnt == CNT_W'(1));

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start, DATA_BITS LSB-first, optional parity, STOP_BITS.
// Build option: UART_TX_PARITY_EN adds the par_odd port and a parity bit.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] data,
   input  logic                 start,
`ifdef UART_TX_PARITY_EN
   input  logic                 par_odd,
`endif
   output logic                 ready,
   output logic                 Tx,
   output logic                 EN_L,
   output logic                 done
);

   if (CLKS_PER_BIT < CLKS_MIN || CLKS_PER_BIT > CLKS_MAX) begin : g_bad_clks
      $fatal(1, "uart_tx_cfg: CLKS_PER_BIT out of range");
   end
   if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data
      $fatal(1, "uart_tx_cfg: DATA_BITS out of range");
   end
   if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop
      $fatal(1, "uart_tx_cfg: STOP_BITS out of range");
   end

   uart_tx_state_t         state, state_d;
   logic [DATA_BITS-1:0]   sr, sr_d;
   logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_d;
   logic [1:0]             rst_sync;
   logic                   tx_d, en_l_d, done_d, ready_d;
   logic                   accept_c, bit_tick, near_tick_c, cnt_en_c;
`ifdef UART_TX_PARITY_EN
   logic                   par_q, par_d;
`endif

   // Release of rst is retimed so start is never taken on the release edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rst_sync <= 2'b00;
      else      rst_sync <= {rst_sync[0], 1'b1};
   end

   assign accept_c = (state == ST_IDLE) && start && rst_sync[1];
   assign cnt_en_c = (state_d != ST_IDLE);

   uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk         (clk),
      .rst         (rst),
      .en          (cnt_en_c),
      .bit_tick    (bit_tick),
      .near_tick_c (near_tick_c)
   );

   // Next-state, shift register and registered-output logic
   always_comb begin
      state_d   = state;
      sr_d      = sr;
      bit_cnt_d = bit_cnt;
`ifdef UART_TX_PARITY_EN
      par_d     = par_q;
`endif
      case (state)
         ST_IDLE: begin
            if (accept_c) begin
               state_d   = ST_START;
               sr_d      = data;
               bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
               par_d     = (^data) ^ par_odd;
`endif
            end
         end
         ST_START: begin
            if (bit_tick) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (bit_tick) begin
               if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
                  bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d   = ST_PARITY;
`else
                  state_d   = ST_STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
                  sr_d      = sr >> 1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_tick) state_d = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (bit_tick) begin
               if (bit_cnt == BIT_CNT_W'(STOP_BITS - 1)) begin
                  state_d   = ST_IDLE;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      tx_d = 1'b1;
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = sr_d[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_d = par_d;
`endif
         default:   tx_d = 1'b1;
      endcase
      en_l_d  = (state_d == ST_IDLE);
      ready_d = (state_d == ST_IDLE);
      // Final stop cycle is the one whose successor edge carries bit_tick
      done_d  = (state == ST_STOP) && (bit_cnt == BIT_CNT_W'(STOP_BITS - 1)) && near_tick_c;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         sr      <= '0;
         bit_cnt <= '0;
         Tx      <= 1'b1;
         EN_L    <= 1'b1;
         ready   <= 1'b1;
         done    <= 1'b0;
      end else begin
         state   <= state_d;
         sr      <= sr_d;
         bit_cnt <= bit_cnt_d;
         Tx      <= tx_d;
         EN_L    <= en_l_d;
         ready   <= ready_d;
         done    <= done_d;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) par_q <= 1'b0;
      else      par_q <= par_d;
   end
`endif

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: two instances (8N1 and 5-bit/2-stop) at 4 clocks per bit.
module tb_uart_tx_cfg;

   localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
   localparam logic [15:0] EXP_8A_EVEN = 16'(11'b11100010100);
   localparam logic [15:0] EXP_F5_ODD  = 16'(11'b11111101010);
   localparam logic [15:0] EXP_F5_EVEN = 16'(11'b10111101010);
   localparam logic [15:0] EXP_1F      = 16'(9'b111111110);
`else
   localparam int P = 0;
   localparam logic [15:0] EXP_8A_EVEN = 16'(10'b1100010100);
   localparam logic [15:0] EXP_F5_ODD  = 16'(10'b1111101010);
   localparam logic [15:0] EXP_F5_EVEN = 16'(10'b1111101010);
   localparam logic [15:0] EXP_1F      = 16'(8'b11111110);
`endif
   localparam int NB1 = 10 + P;
   localparam int NB2 = 8 + P;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data1;
   logic [4:0] data2;
   logic       start1, start2;
   logic       ready1, tx1, enl1, done1;
   logic       ready2, tx2, enl2, done2;
`ifdef UART_TX_PARITY_EN
   logic       podd1, podd2;
`endif
   int         sel;
   logic       s_tx, s_enl, s_ready, s_done;
   int         n_checks = 0;
   int         n_pass   = 0;

   always #5 clk = ~clk;

   uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)) dut (
      .clk(clk), .rst(rst), .data(data1), .start(start1),
`ifdef UART_TX_PARITY_EN
      .par_odd(podd1),
`endif
      .ready(ready1), .Tx(tx1), .EN_L(enl1), .done(done1)
   );

   uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst(rst), .data(data2), .start(start2),
`ifdef UART_TX_PARITY_EN
      .par_odd(podd2),
`endif
      .ready(ready2), .Tx(tx2), .EN_L(enl2), .done(done2)
   );

   assign s_tx    = (sel != 0) ? tx2    : tx1;
   assign s_enl   = (sel != 0) ? enl2   : enl1;
   assign s_ready = (sel != 0) ? ready2 : ready1;
   assign s_done  = (sel != 0) ? done2  : done1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else
         n_pass++;
   endtask

   task automatic set_start(input logic v);
      if (sel != 0) start2 = v;
      else          start1 = v;
   endtask

   // Sends one frame, samples every cycle and compares against the hand-built bit pattern
   task automatic run_frame(input int s, input logic [7:0] d, input logic podd,
                            input int nbits, input logic [15:0] exp_bits, input string tag);
      int len, glitch, done_at, done_n, busy_bad;
      logic [15:0] obs;
      len = nbits * int'(CPB);
      glitch = 0; done_at = -1; done_n = 0; busy_bad = 0; obs = '0;
      sel = s;
      @(negedge clk);
      if (s != 0) data2 = d[4:0];
      else        data1 = d;
`ifdef UART_TX_PARITY_EN
      if (s != 0) podd2 = podd;
      else        podd1 = podd;
`else
      if (podd) glitch = 0;
`endif
      set_start(1'b1);
      @(posedge clk); #1;
      set_start(1'b0);
      if (s != 0) data2 = ~data2;
      else        data1 = ~data1;
      for (int i = 0; i < len; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         if (i % int'(CPB) == 0) obs[i / int'(CPB)] = s_tx;
         else if (s_tx !== obs[i / int'(CPB)]) glitch++;
         if (s_enl !== 1'b0 || s_ready !== 1'b0) busy_bad++;
         if (s_done === 1'b1) begin
            done_n++;
            if (done_at < 0) done_at = i;
         end
         if (i == 10) set_start(1'b1);
         if (i == 11) set_start(1'b0);
      end
      check({tag, "_bits"}, 32'(obs), 32'(exp_bits));
      check({tag, "_glitch"}, 32'(glitch), 32'd0);
      check({tag, "_busy"}, 32'(busy_bad), 32'd0);
      check({tag, "_done_at"}, 32'(done_at), 32'(len - 1));
      check({tag, "_done_n"}, 32'(done_n), 32'd1);
      @(posedge clk); #1;
      check({tag, "_idle"}, {28'd0, s_ready, s_tx, s_enl, s_done}, 32'b1110);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int len, rdy_n, done_n;
      sel = 0;
      rst = 1'b1; start1 = 1'b0; start2 = 1'b0; data1 = '0; data2 = '0;
`ifdef UART_TX_PARITY_EN
      podd1 = 1'b0; podd2 = 1'b0;
`endif
      #2 rst = 1'b0;
      #1;
      check("rst_dut1", {28'd0, ready1, tx1, enl1, done1}, 32'b1110);
      check("rst_dut2", {28'd0, ready2, tx2, enl2, done2}, 32'b1110);
      @(negedge clk); rst = 1'b1;
      repeat (4) @(posedge clk);

      run_frame(0, 8'h8A, 1'b0, NB1, EXP_8A_EVEN, "f8a_even");
      run_frame(0, 8'hF5, 1'b1, NB1, EXP_F5_ODD,  "ff5_odd");
      run_frame(0, 8'hF5, 1'b0, NB1, EXP_F5_EVEN, "ff5_even");
      run_frame(1, 8'h1F, 1'b0, NB2, EXP_1F,      "f1f_2stop");

      // Back-to-back frames with start held
      sel = 0;
      len = NB1 * int'(CPB);
      rdy_n = 0; done_n = 0;
      @(negedge clk); data1 = 8'h55; start1 = 1'b1;
      @(posedge clk); #1;
      for (int i = 1; i <= 2 * len + 1; i++) begin
         @(posedge clk); #1;
         if (i <= 2 * len && ready1 === 1'b1) rdy_n++;
         if (done1 === 1'b1) done_n++;
         if (i == len - 1) check("b2b_done1", 32'(done1), 32'd1);
         if (i == len) check("b2b_gap", {29'd0, ready1, tx1, enl1}, 32'b111);
         if (i == len + 1) begin
            check("b2b_reaccept", {29'd0, ready1, tx1, enl1}, 32'b000);
            start1 = 1'b0;
         end
         if (i == len + 1 + int'(CPB)) check("b2b_d0", 32'(tx1), 32'd1);
         if (i == 2 * len) check("b2b_done2", 32'(done1), 32'd1);
         if (i == 2 * len + 1) check("b2b_end", 32'(ready1), 32'd1);
      end
      check("b2b_gap_len", 32'(rdy_n), 32'd1);
      check("b2b_done_n", 32'(done_n), 32'd2);

      // Reset in the middle of a frame
      @(negedge clk); data1 = 8'h8A; start1 = 1'b1;
      @(posedge clk); #1; start1 = 1'b0;
      repeat (15) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("midrst_async", {28'd0, ready1, tx1, enl1, done1}, 32'b1110);
      done_n = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (done1 === 1'b1) done_n++;
      end
      @(negedge clk); rst = 1'b1; start1 = 1'b1;
      @(posedge clk); #1;
      if (done1 === 1'b1) done_n++;
      check("release_no_accept", {30'd0, ready1, tx1}, 32'b11);
      start1 = 1'b0;
      repeat (3) @(posedge clk);
      #1 if (done1 === 1'b1) done_n++;
      check("midrst_no_done", 32'(done_n), 32'd0);
      run_frame(0, 8'hF5, 1'b1, NB1, EXP_F5_ODD, "post_rst_f5");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
